// File: rtl/enc8to3_seq_if.sv
// Request/code bundle between a requester/consumer pair and the 8-to-3 priority encoder.
interface enc8to3_seq_if;
  logic [7:0] i;
  logic       e;
  logic       ready;
  logic [2:0] y;
  logic       y_valid;
  logic [7:0] pend;

  modport master (output i, e, ready, input y, y_valid, pend);
  modport slave  (input i, e, ready, output y, y_valid, pend);
endinterface

// File: rtl/enc8to3_seq.sv
// Registered 8-to-3 priority encoder over a sticky pending register; 2-cycle request-to-valid.
// y is held with y_valid until ready; a new code follows only after one idle cycle.
module enc8to3_seq (
  input  logic        clk,
  input  logic        rst_n,
  enc8to3_seq_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] pend_q;
  logic [7:0] pend_d;
  logic [2:0] y_q;
  logic [2:0] top;
  logic [7:0] clr;
  logic       y_valid;

  // Highest set bit wins: later iterations overwrite lower indices.
  always_comb begin
    top = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (pend_q[k]) top = 3'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pend_q != 8'h00) state_d = HOLD;
      HOLD: if (bus.ready)       state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_comb begin
    y_valid = (state_q == HOLD);
    clr     = 8'h00;
    if (y_valid && bus.ready) clr = 8'h01 << y_q;
  end

  // A fresh request on the same bit as the clear takes precedence.
  assign pend_d = (pend_q & ~clr) | (bus.e ? bus.i : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 8'h00;
    else        pend_q <= pend_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 y_q <= 3'd0;
    else if (state_q == IDLE && pend_q != 8'h00) y_q <= top;
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid;
  assign bus.pend    = pend_q;

  a_served_pending: assert property (@(posedge clk) disable iff (!rst_n)
    y_valid |-> pend_q[y_q]);
  a_gap_after_xfer: assert property (@(posedge clk) disable iff (!rst_n)
    (y_valid && bus.ready) |=> !y_valid);

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed bench for enc8to3_seq: hand-computed codes, pending values and handshake timing.
module tb_enc8to3_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  enc8to3_seq_if bus ();

  enc8to3_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_code;
    int served;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.i     = 8'h00;
    bus.e     = 1'b0;
    bus.ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.y_valid), 32'd0);
    chk("rst_pend",  32'(bus.pend),    32'h00);
    chk("rst_y",     32'(bus.y),       32'd0);
    rst_n = 1'b1;

    // Single request, consumer stalls then accepts
    bus.e = 1'b1; bus.i = 8'h10;
    step(); bus.i = 8'h00;
    chk("single_pend1",  32'(bus.pend),    32'h10);
    chk("single_valid1", 32'(bus.y_valid), 32'd0);
    step();
    chk("single_y",      32'(bus.y),       32'd4);
    chk("single_valid2", 32'(bus.y_valid), 32'd1);
    step();
    chk("single_hold_y", 32'(bus.y),       32'd4);
    chk("single_hold_v", 32'(bus.y_valid), 32'd1);
    bus.ready = 1'b1;
    step(); bus.ready = 1'b0;
    chk("single_clr_pend", 32'(bus.pend),    32'h00);
    chk("single_clr_v",    32'(bus.y_valid), 32'd0);
    chk("single_keep_y",   32'(bus.y),       32'd4);

    // Priority drain with ready held high: 7, 2, 0
    bus.ready = 1'b1; bus.i = 8'h85;
    step(); bus.i = 8'h00;
    chk("drain_pend0", 32'(bus.pend), 32'h85);
    step(); chk("drain_y7", 32'(bus.y), 32'd7); chk("drain_v7", 32'(bus.y_valid), 32'd1);
    step(); chk("drain_gap1", 32'(bus.y_valid), 32'd0); chk("drain_pend1", 32'(bus.pend), 32'h05);
    step(); chk("drain_y2", 32'(bus.y), 32'd2); chk("drain_v2", 32'(bus.y_valid), 32'd1);
    step(); chk("drain_gap2", 32'(bus.y_valid), 32'd0); chk("drain_pend2", 32'(bus.pend), 32'h01);
    step(); chk("drain_y0", 32'(bus.y), 32'd0); chk("drain_v0", 32'(bus.y_valid), 32'd1);
    step(); chk("drain_end_v", 32'(bus.y_valid), 32'd0); chk("drain_end_pend", 32'(bus.pend), 32'h00);
    step(); chk("drain_idle", 32'(bus.y_valid), 32'd0);
    bus.ready = 1'b0;

    // Higher-priority arrival while holding does not disturb y
    bus.i = 8'h02;
    step(); bus.i = 8'h00;
    step(); chk("frz_y1", 32'(bus.y), 32'd1); chk("frz_v1", 32'(bus.y_valid), 32'd1);
    bus.i = 8'h40;
    step(); bus.i = 8'h00;
    chk("frz_y_hold", 32'(bus.y), 32'd1);
    chk("frz_pend",   32'(bus.pend), 32'h42);
    step(); chk("frz_y_hold2", 32'(bus.y), 32'd1);
    bus.ready = 1'b1;
    step(); bus.ready = 1'b0;
    chk("frz_xfer_v",    32'(bus.y_valid), 32'd0);
    chk("frz_xfer_pend", 32'(bus.pend),    32'h40);
    step(); chk("frz_next_y", 32'(bus.y), 32'd6); chk("frz_next_v", 32'(bus.y_valid), 32'd1);
    bus.ready = 1'b1;
    step(); bus.ready = 1'b0;
    chk("frz_done_pend", 32'(bus.pend), 32'h00);

    // Enable gating
    bus.e = 1'b0; bus.i = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("gate_pend",  32'(bus.pend),    32'h00);
      chk("gate_valid", 32'(bus.y_valid), 32'd0);
    end
    bus.e = 1'b1;
    step(); bus.e = 1'b0; bus.i = 8'h00;
    chk("gate_pend_ff", 32'(bus.pend), 32'hFF);
    step();
    chk("gate_first_y", 32'(bus.y), 32'd7);
    bus.ready = 1'b1;
    exp_code = 7;
    served   = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.y_valid) begin
        chk("gate_code", 32'(bus.y), 32'(exp_code));
        exp_code--;
        served++;
      end
      if (bus.pend == 8'h00 && !bus.y_valid) break;
      step();
    end
    chk("gate_served", 32'(served), 32'd8);
    bus.ready = 1'b0;
    bus.e     = 1'b1;

    // Set/clear collision on the handshake edge
    bus.i = 8'h08;
    step();
    step(); chk("col_y3", 32'(bus.y), 32'd3); chk("col_v3", 32'(bus.y_valid), 32'd1);
    bus.ready = 1'b1;
    step(); bus.ready = 1'b0; bus.i = 8'h00;
    chk("col_pend_kept", 32'(bus.pend),    32'h08);
    chk("col_gap",       32'(bus.y_valid), 32'd0);
    step(); chk("col_again_y", 32'(bus.y), 32'd3); chk("col_again_v", 32'(bus.y_valid), 32'd1);
    bus.ready = 1'b1;
    step(); bus.ready = 1'b0;
    chk("col_done_pend", 32'(bus.pend), 32'h00);

    // Asynchronous reset mid-handshake
    bus.i = 8'h20;
    step(); bus.i = 8'h00;
    step(); chk("ar_y5", 32'(bus.y), 32'd5); chk("ar_pend", 32'(bus.pend), 32'h20);
    bus.ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.y_valid), 32'd0);
    chk("ar_pend0", 32'(bus.pend),    32'h00);
    chk("ar_y0",    32'(bus.y),       32'd0);
    bus.ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.i = 8'h01;
    step(); bus.i = 8'h00;
    chk("ar_first_capture", 32'(bus.pend), 32'h01);
    step(); chk("ar_first_y", 32'(bus.y), 32'd0); chk("ar_first_v", 32'(bus.y_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
